wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file of the 5-stage core; the consumer end of the MEM/WB pipeline register. Selects the writeback value (ALU result, load data, or jump link address), commits it to a 32-entry integer register file on the clock edge, and serves two decode-stage read ports with write-first bypass. Also drives the WB forwarding bus to the EX forwarding unit and keeps a committed-write counter for debug.

## Interface
Parameters:
- WORD_SIZE, 32, data/register width
- NUM_WORDS, 1024, instruction memory depth in words
- NUM_REGS, 32, architectural registers; entry 0 is hardwired zero
- REG_SEL, $clog2(NUM_REGS), register index width
- ADDR_SIZE, $clog2(NUM_WORDS), PC width (word index)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_pc  in  ADDR_SIZE  word-index PC of the retiring instruction
- wb_read_data  in  WORD_SIZE  load data from MEM/WB
- wb_result  in  WORD_SIZE  ALU result from MEM/WB
- wb_rd  in  REG_SEL  destination register
- wb_mem_to_reg  in  1  select load data
- wb_jump  in  1  select link address
- wb_reg_write  in  1  commit enable
- rs1_addr, rs2_addr  in  REG_SEL each  decode read addresses
- rs1_data, rs2_data  out  WORD_SIZE each  decode read data (combinational)
- fwd_valid  out  1  WB forwarding entry valid
- fwd_rd  out  REG_SEL  WB forwarding destination
- fwd_data  out  WORD_SIZE  WB forwarding value
- wb_count  out  32  committed-write counter

## Operation
- Writeback select, priority: wb_jump -> link; else wb_mem_to_reg -> wb_read_data; else wb_result.
- Link = zero-extended ({wb_pc + 1} << 2), computed at WORD_SIZE width: no wrap at ADDR_SIZE; wb_pc = 1023 gives 0x0000_1000.
- Commit: wb_reg_write = 1 and wb_rd != 0 writes the selected value to entry wb_rd at the rising edge. Writes to rd = 0 are dropped; entry 0 reads 0 always.
- Reads: rsN_data = 0 if rsN_addr = 0; else if commit pending this cycle and wb_rd == rsN_addr, the selected writeback value (write-first bypass); else stored entry.
- Forwarding: fwd_valid = wb_reg_write && wb_rd != 0; fwd_rd = wb_rd; fwd_data = selected value. All combinational.
- wb_count increments by 1 on every committing edge (same condition as fwd_valid); wraps 0xFFFF_FFFF -> 0.
- A flushed MEM/WB bubble (all zero) performs no write and does not count.
- A held (stalled) MEM/WB output repeats the same write each cycle: architecturally idempotent, but each edge counts.

## Timing
- Reset (rst_n low, asynchronous): all register entries -> 0, wb_count -> 0; read ports and forwarding outputs follow the zeroed state immediately.
- Release of rst_n is synchronised externally; the first commit occurs on the first rising edge with rst_n high.
- Write latency: visible on the stored path from the edge after commit; visible same cycle via bypass and forwarding bus.
- Reads are zero-latency combinational; no read enable.
- rst_n asserted in the same cycle as a commit: reset wins, the write is lost, counter stays 0.

## Structure
- Shared package riscv_pkg: WORD_SIZE, NUM_REGS, REG_SEL, ADDR_SIZE defaults; x0 index constant; writeback-select encoding constants (WB_ALU, WB_MEM, WB_LINK).
- One sub-module, regfile_core: the storage array with async reset, one write port, two raw read ports. The wb_regfile top holds the select mux, bypass, forwarding, and counter.

## Test plan
- Reset then read all 32 regs -> all 0; wb_count = 0; fwd_valid = 0.
- wb_reg_write=1, wb_rd=5, wb_result=0xDEAD_BEEF, rs1_addr=5 same cycle -> rs1_data=0xDEAD_BEEF (bypass), fwd_data=0xDEAD_BEEF; after edge stored x5 = 0xDEAD_BEEF; wb_count = 1.
- wb_mem_to_reg=1, wb_jump=1, wb_pc=0x3FF, wb_rd=1 -> x1 = 0x0000_1000 (jump priority, no wrap).
- wb_reg_write=1, wb_rd=0, wb_result=0x1234 -> x0 reads 0, fwd_valid=0, wb_count unchanged.
- Write x7 = 0xA5A5_A5A5, then pulse rst_n low mid-cycle -> x7 = 0 and wb_count = 0 immediately, before any clock edge.
- Hold one commit for 3 cycles, rd=9, data 0x55 -> x9 = 0x55, wb_count advances by 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants: default widths, the hardwired-zero register index,
// and the writeback-select encoding used by the WB stage.
package riscv_pkg;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_NUM_WORDS = 1024;
    localparam int DEF_NUM_REGS  = 32;
    localparam int DEF_REG_SEL   = $clog2(DEF_NUM_REGS);
    localparam int DEF_ADDR_SIZE = $clog2(DEF_NUM_WORDS);

    localparam int X0 = 0;

    typedef logic [1:0] wb_sel_t;
    localparam wb_sel_t WB_ALU  = 2'd0;
    localparam wb_sel_t WB_MEM  = 2'd1;
    localparam wb_sel_t WB_LINK = 2'd2;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB pipeline register outputs as seen by the writeback stage.
// The MEM/WB register drives (master); wb_regfile consumes (slave). No handshake:
// the fields are sampled every cycle and a bubble is all-zero.
interface wb_regfile_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int REG_SEL   = 5
);
    logic [ADDR_SIZE-1:0] wb_pc;
    logic [WORD_SIZE-1:0] wb_read_data;
    logic [WORD_SIZE-1:0] wb_result;
    logic [REG_SEL-1:0]   wb_rd;
    logic                 wb_mem_to_reg;
    logic                 wb_jump;
    logic                 wb_reg_write;

    modport master (
        output wb_pc, wb_read_data, wb_result, wb_rd,
               wb_mem_to_reg, wb_jump, wb_reg_write
    );

    modport slave (
        input  wb_pc, wb_read_data, wb_result, wb_rd,
               wb_mem_to_reg, wb_jump, wb_reg_write
    );
endinterface

// File: rtl/regfile_core.sv
// Register storage: async-reset array, one write port, two raw read ports.
// Entry-0 masking and bypass are handled by the caller.
module regfile_core #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_SEL-1:0]   waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [REG_SEL-1:0]   raddr1,
    input  logic [REG_SEL-1:0]   raddr2,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic [WORD_SIZE-1:0] rdata2
);

    logic [WORD_SIZE-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the retiring value, commits it to the register file,
// serves two bypassed decode read ports, drives the WB forwarding bus and a commit counter.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int ADDR_SIZE = $clog2(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_regfile_if.slave          wb,
    input  logic [REG_SEL-1:0]   rs1_addr,
    input  logic [REG_SEL-1:0]   rs2_addr,
    output logic [WORD_SIZE-1:0] rs1_data,
    output logic [WORD_SIZE-1:0] rs2_data,
    output logic                 fwd_valid,
    output logic [REG_SEL-1:0]   fwd_rd,
    output logic [WORD_SIZE-1:0] fwd_data,
    output logic [31:0]          wb_count
);

    wb_sel_t              wb_sel;
    logic [WORD_SIZE-1:0] link;
    logic [WORD_SIZE-1:0] wb_value;
    logic [WORD_SIZE-1:0] raw1;
    logic [WORD_SIZE-1:0] raw2;
    logic                 commit;

    always_comb begin
        wb_sel = WB_ALU;
        if (wb.wb_jump) begin
            wb_sel = WB_LINK;
        end else if (wb.wb_mem_to_reg) begin
            wb_sel = WB_MEM;
        end
    end

    // Widen before the increment so the last word of memory links to 0x1000, not 0.
    assign link = (WORD_SIZE'(wb.wb_pc) + WORD_SIZE'(1)) << 2;

    always_comb begin
        wb_value = wb.wb_result;
        case (wb_sel)
            WB_LINK: wb_value = link;
            WB_MEM:  wb_value = wb.wb_read_data;
            default: wb_value = wb.wb_result;
        endcase
    end

    assign commit = wb.wb_reg_write && (wb.wb_rd != REG_SEL'(X0));

    regfile_core #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS),
        .REG_SEL   (REG_SEL)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (commit),
        .waddr  (wb.wb_rd),
        .wdata  (wb_value),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (raw1),
        .rdata2 (raw2)
    );

    // Write-first: a commit landing this edge is already visible to decode.
    always_comb begin
        rs1_data = raw1;
        if (rs1_addr == REG_SEL'(X0)) begin
            rs1_data = '0;
        end else if (commit && (wb.wb_rd == rs1_addr)) begin
            rs1_data = wb_value;
        end
    end

    always_comb begin
        rs2_data = raw2;
        if (rs2_addr == REG_SEL'(X0)) begin
            rs2_data = '0;
        end else if (commit && (wb.wb_rd == rs2_addr)) begin
            rs2_data = wb_value;
        end
    end

    assign fwd_valid = commit;
    assign fwd_rd    = wb.wb_rd;
    assign fwd_data  = wb_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= '0;
        end else if (commit) begin
            wb_count <= wb_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: the driver queues expected observations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_regfile;

    localparam int K_RS1 = 0;
    localparam int K_RS2 = 1;
    localparam int K_FV  = 2;
    localparam int K_FRD = 3;
    localparam int K_FD  = 4;
    localparam int K_CNT = 5;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] wb_count;

    wb_regfile_if #(.WORD_SIZE(32), .ADDR_SIZE(10), .REG_SEL(5)) mw ();

    wb_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (mw.slave),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .wb_count  (wb_count)
    );

    // ---------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard
    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       tag_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic expect_val(input int kind, input logic [31:0] value, input string tag);
        kind_q.push_back(kind);
        exp_q.push_back(value);
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] a;
            int          k;
            string       t;
            e = exp_q.pop_front();
            k = kind_q.pop_front();
            t = tag_q.pop_front();
            case (k)
                K_RS1:   a = rs1_data;
                K_RS2:   a = rs2_data;
                K_FV:    a = {31'd0, fwd_valid};
                K_FRD:   a = {27'd0, fwd_rd};
                K_FD:    a = fwd_data;
                default: a = wb_count;
            endcase
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", t, a, e);
            end
        end
    end

    // ---------------- driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        mw.wb_pc         = '0;
        mw.wb_read_data  = '0;
        mw.wb_result     = '0;
        mw.wb_rd         = '0;
        mw.wb_mem_to_reg = 1'b0;
        mw.wb_jump       = 1'b0;
        mw.wb_reg_write  = 1'b0;
    endtask

    task automatic drive_wb(input logic [9:0] pc, input logic [31:0] rdata,
                            input logic [31:0] res, input logic [4:0] rd,
                            input logic m2r, input logic jmp, input logic we);
        mw.wb_pc         = pc;
        mw.wb_read_data  = rdata;
        mw.wb_result     = res;
        mw.wb_rd         = rd;
        mw.wb_mem_to_reg = m2r;
        mw.wb_jump       = jmp;
        mw.wb_reg_write  = we;
    endtask

    // Commit one value, then read it back from the stored path the next cycle.
    task automatic commit_and_read(input logic [9:0] pc, input logic [31:0] rdata,
                                   input logic [31:0] res, input logic [4:0] rd,
                                   input logic m2r, input logic jmp,
                                   input logic [31:0] exp_v, input logic [31:0] exp_cnt,
                                   input string tag);
        drive_wb(pc, rdata, res, rd, m2r, jmp, 1'b1);
        expect_val(K_FD, exp_v, {tag, "_fwd_data"});
        expect_val(K_FV, 32'd1, {tag, "_fwd_valid"});
        step();
        bubble();
        rs2_addr = rd;
        expect_val(K_RS2, exp_v, {tag, "_stored"});
        expect_val(K_CNT, exp_cnt, {tag, "_count"});
        step();
    endtask

    initial begin
        rst_n    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        bubble();
        expect_val(K_CNT, 32'd0, "reset_count");
        expect_val(K_FV, 32'd0, "reset_fwd_valid");
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            expect_val(K_RS1, 32'd0, $sformatf("reset_rs1_x%0d", i));
            expect_val(K_RS2, 32'd0, $sformatf("reset_rs2_x%0d", 31 - i));
            step();
        end
        expect_val(K_CNT, 32'd0, "idle_count");

        // ALU writeback with same-cycle bypass on both ports
        drive_wb(10'd0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd5, 1'b0, 1'b0, 1'b1);
        rs1_addr = 5'd5;
        rs2_addr = 5'd5;
        expect_val(K_RS1, 32'hDEAD_BEEF, "bypass_rs1_x5");
        expect_val(K_RS2, 32'hDEAD_BEEF, "bypass_rs2_x5");
        expect_val(K_FD, 32'hDEAD_BEEF, "fwd_data_x5");
        expect_val(K_FRD, 32'd5, "fwd_rd_x5");
        expect_val(K_FV, 32'd1, "fwd_valid_x5");
        expect_val(K_CNT, 32'd0, "count_before_edge");
        step();
        bubble();
        expect_val(K_RS1, 32'hDEAD_BEEF, "stored_x5");
        expect_val(K_CNT, 32'd1, "count_after_x5");
        expect_val(K_FV, 32'd0, "bubble_fwd_valid");
        step();

        // Jump beats mem_to_reg; link does not wrap at the PC width
        commit_and_read(10'h3FF, 32'h1111_1111, 32'h2222_2222, 5'd1, 1'b1, 1'b1,
                        32'h0000_1000, 32'd2, "link_max_pc");
        commit_and_read(10'd5, 32'h1111_1111, 32'h2222_2222, 5'd2, 1'b0, 1'b1,
                        32'h0000_0018, 32'd3, "link_pc5");
        commit_and_read(10'd7, 32'hCAFE_F00D, 32'h2222_2222, 5'd3, 1'b1, 1'b0,
                        32'hCAFE_F00D, 32'd4, "load_sel");

        // Write to x0 is dropped and not counted
        drive_wb(10'd0, 32'd0, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b1);
        rs1_addr = 5'd0;
        expect_val(K_RS1, 32'd0, "x0_bypass");
        expect_val(K_FV, 32'd0, "x0_fwd_valid");
        step();
        bubble();
        expect_val(K_RS1, 32'd0, "x0_stored");
        expect_val(K_CNT, 32'd4, "x0_count");
        step();

        // x7 then asynchronous reset mid-cycle
        commit_and_read(10'd0, 32'd0, 32'hA5A5_A5A5, 5'd7, 1'b0, 1'b0,
                        32'hA5A5_A5A5, 32'd5, "x7_write");
        rst_n    = 1'b0;
        rs1_addr = 5'd7;
        expect_val(K_RS1, 32'd0, "async_reset_x7");
        expect_val(K_CNT, 32'd0, "async_reset_count");
        step();
        drive_wb(10'd0, 32'd0, 32'h0000_0099, 5'd7, 1'b0, 1'b0, 1'b1);
        step();
        bubble();
        rst_n = 1'b1;
        expect_val(K_RS1, 32'd0, "reset_wins_x7");
        expect_val(K_CNT, 32'd0, "reset_wins_count");
        step();

        // Stalled MEM/WB: same write held for three edges
        drive_wb(10'd0, 32'd0, 32'h0000_0055, 5'd9, 1'b0, 1'b0, 1'b1);
        rs2_addr = 5'd9;
        expect_val(K_RS2, 32'h0000_0055, "hold_bypass_x9");
        expect_val(K_CNT, 32'd0, "hold_count0");
        step();
        expect_val(K_CNT, 32'd1, "hold_count1");
        step();
        expect_val(K_CNT, 32'd2, "hold_count2");
        step();
        bubble();
        rs1_addr = 5'd9;
        expect_val(K_RS1, 32'h0000_0055, "hold_stored_x9");
        expect_val(K_CNT, 32'd3, "hold_count3");
        expect_val(K_RS2, 32'h0000_0055, "hold_stored_rs2_x9");
        step();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
